ifetch_queue: RTL and testbench

- Instruction fetch front end that sits directly upstream of the single-cycle cpu datapath.
- Generates sequential word-aligned fetch addresses to an instruction memory with a valid/ready request channel and in-order responses.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to the decode/execute stage over a valid/ready handshake.
- Handles branch/jump redirects from the cpu by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/ifetch_queue_pkg.sv | 16 +
 rtl/ifetch_queue_fifo.sv | 65 ++++++
 rtl/ifetch_queue.sv | 104 ++++++++++
 tb/tb_ifetch_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : ifetch_queue_pkg
// Description : Shared constants for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package ifetch_queue_pkg;

    localparam int unsigned c_INST_WIDTH       = 32;
    localparam logic [31:0] c_PC_INC           = 32'd4;
    // Low address bits that must be zero for a word-aligned fetch.
    localparam logic [1:0]  c_ALIGN_MASK       = 2'b11;
    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous clear; data path only.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign full      = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : ifetch_queue
// Description : Sequential instruction fetch with credit-limited requests,
//               in-order response buffering and redirect flush/drop handling.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned      WIDTH    = c_INST_WIDTH,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(c_DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             req_valid,
    output logic [WIDTH-1:0] req_addr,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_data,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc
);

    localparam int unsigned      c_CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned      c_DROP_W    = $clog2(2 * DEPTH) + 1;
    localparam logic [WIDTH-1:0] c_INC       = WIDTH'(c_PC_INC);
    localparam logic [WIDTH-1:0] c_MASK      = ~{{(WIDTH - 2){1'b0}}, c_ALIGN_MASK};
    localparam logic [c_CNT_W:0] c_DEPTH_OCC = (c_CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_fetch_pc;
    logic [WIDTH-1:0]    r_head_pc;
    logic [c_CNT_W-1:0]  r_inflight;
    logic [c_DROP_W-1:0] r_drop;

    logic [c_CNT_W-1:0]  w_count;
    logic                w_full;
    logic                w_empty;
    logic [WIDTH-1:0]    w_head_data;
    logic [c_CNT_W:0]    w_occupancy;
    logic                w_req_fire;
    logic                w_rsp_hit;
    logic                w_rsp_drop;
    logic                w_push;
    logic                w_pop;

    // Credit covers buffered plus live in-flight fetches; stale ones hold no FIFO slot.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_inflight};
    assign req_valid   = rst & ~redirect & (w_occupancy < c_DEPTH_OCC);
    assign req_addr    = r_fetch_pc;
    assign w_req_fire  = req_valid & req_ready;

    assign w_rsp_drop  = rsp_valid & (r_drop != '0);
    assign w_rsp_hit   = rsp_valid & ((r_drop != '0) | (r_inflight != '0));
    assign w_push      = rsp_valid & ~redirect & (r_drop == '0) & (r_inflight != '0) & ~w_full;
    assign w_pop       = inst_valid & inst_ready & ~redirect;

    assign inst_valid  = ~w_empty;
    assign inst        = w_empty ? '0 : w_head_data;
    assign inst_pc     = r_head_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & c_MASK;
            r_head_pc  <= redirect_pc & c_MASK;
            r_inflight <= '0;
            // Every outstanding live fetch becomes stale, less the one answered now.
            r_drop     <= r_drop + c_DROP_W'(r_inflight) - c_DROP_W'(w_rsp_hit);
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + c_INC;
            if (w_pop)      r_head_pc  <= r_head_pc + c_INC;
            r_inflight <= r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(w_push);
            if (w_rsp_drop) r_drop <= r_drop - c_DROP_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (rsp_data),
        .pop       (w_pop),
        .head_data (w_head_data),
        .clear     (redirect),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_ifetch_queue
// Description : Directed self-checking bench for ifetch_queue (two instances,
//               one with a wrapping reset PC). Memory returns ~addr as data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, rsp_valid, inst_valid, inst_ready, redirect;
    logic [31:0] req_addr, rsp_data, inst, inst_pc, redirect_pc;
    logic        req_valid_b, req_ready_b, rsp_valid_b, inst_valid_b, inst_ready_b, redirect_b;
    logic [31:0] req_addr_b, rsp_data_b, inst_b, inst_pc_b, redirect_pc_b;

    ifetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    ifetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_addr(req_addr_b), .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .inst_valid(inst_valid_b), .inst(inst_b), .inst_pc(inst_pc_b), .inst_ready(inst_ready_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_fires  = 0;
    int          n_pops   = 0;
    int          p0, f0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc, exp_req, exp_pc_b, exp_req_b;
    logic        pend_b;
    logic [31:0] pend_b_addr;
    logic        redir_req;
    logic [31:0] redir_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, expected);
    endtask

    task automatic clear_model();
        rsp_valid   = 1'b0;
        rsp_valid_b = 1'b0;
        redirect    = 1'b0;
        redir_req   = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        pend_b      = 1'b0;
        exp_pc      = 32'h0;
        exp_req     = 32'h0;
        exp_pc_b    = 32'hFFFF_FFF8;
        exp_req_b   = 32'hFFFF_FFF8;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at negedge, observe handshakes, advance to next negedge.
    task automatic tick();
        logic [31:0] a;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            a         = mq_addr.pop_front();
            void'(mq_due.pop_front());
            rsp_valid = 1'b1;
            rsp_data  = ~a;
        end
        redirect    = redir_req;
        redirect_pc = redir_pc;
        rsp_valid_b = pend_b;
        rsp_data_b  = ~pend_b_addr;
        #1;
        if (inst_valid && inst_ready) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (redirect) begin
            check("req_valid_in_redirect", req_valid, 1'b0);
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_req = exp_pc;
        end
        if (req_valid && req_ready) begin
            check("req_addr", req_addr, exp_req);
            mq_addr.push_back(req_addr);
            mq_due.push_back(cyc + lat);
            exp_req = exp_req + 32'd4;
            n_fires++;
        end
        if (inst_valid_b) begin
            check("wrap_inst_pc", inst_pc_b, exp_pc_b);
            check("wrap_inst_data", inst_b, ~exp_pc_b);
            exp_pc_b = exp_pc_b + 32'd4;
        end
        pend_b      = req_valid_b;
        pend_b_addr = req_addr_b;
        if (req_valid_b) begin
            check("wrap_req_addr", req_addr_b, exp_req_b);
            exp_req_b = exp_req_b + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        req_ready = 1'b1; inst_ready = 1'b1;
        rsp_valid = 1'b0; rsp_data = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
        req_ready_b = 1'b1; inst_ready_b = 1'b1;
        rsp_valid_b = 1'b0; rsp_data_b = 32'h0; redirect_b = 1'b0; redirect_pc_b = 32'h0;
        pend_b_addr = 32'h0; redir_pc = 32'h0;
        clear_model();

        // Reset state
        #7;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_wrap_inst_pc", inst_pc_b, 32'hFFFF_FFF8);
        check("rst_wrap_req_valid", req_valid_b, 1'b0);
        @(negedge clk);

        // Streaming, 1-cycle memory
        do_reset();
        lat = 1;
        #1;
        check("t1_first_req_valid", req_valid, 1'b1);
        check("t1_first_req_addr", req_addr, 32'h0);
        repeat (10) tick();
        p0 = n_pops;
        repeat (20) tick();
        check("t1_throughput", n_pops - p0, 20);

        // Consumer stall fills the FIFO, then drains in order
        do_reset();
        lat = 1;
        inst_ready = 1'b0;
        f0 = n_fires;
        repeat (10) tick();
        check("t2_fires", n_fires - f0, 4);
        check("t2_req_valid_low", req_valid, 1'b0);
        check("t2_inst_valid", inst_valid, 1'b1);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        p0 = n_pops;
        repeat (10) tick();
        check("t2_drain_pops", n_pops - p0, 10);

        // Redirect with two stale fetches in flight, 3-cycle memory
        do_reset();
        lat = 3;
        repeat (2) tick();
        redir_req = 1'b1; redir_pc = 32'h0000_0103;
        tick();
        redir_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) break;
            tick();
        end
        check("t3_first_valid", inst_valid, 1'b1);
        check("t3_first_pc", inst_pc, 32'h0000_0100);
        check("t3_first_data", inst, ~32'h0000_0100);
        repeat (10) tick();

        // Redirect coinciding with a response and a would-be request
        do_reset();
        lat = 2;
        repeat (6) tick();
        check("t4_req_pending", req_valid, 1'b1);
        redir_req = 1'b1; redir_pc = 32'h0000_2001;
        tick();
        redir_req = 1'b0;
        p0 = n_pops;
        repeat (15) tick();
        check("t4_pops_after_redirect", n_pops - p0, 12);
        check("t4_next_pc", inst_pc, exp_pc);

        // Asynchronous reset mid-operation
        do_reset();
        lat = 3;
        inst_ready = 1'b0;
        repeat (4) tick();
        check("t6_nonempty", inst_valid, 1'b1);
        check("t6_credit_stall", req_valid, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_req_valid", req_valid, 1'b0);
        check("t6_async_inst_valid", inst_valid, 1'b0);
        check("t6_async_inst", inst, 32'h0);
        check("t6_async_inst_pc", inst_pc, 32'h0);
        check("t6_async_wrap_pc", inst_pc_b, 32'hFFFF_FFF8);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        inst_ready = 1'b1;
        lat = 1;
        #1;
        check("t6_restart_valid", req_valid, 1'b1);
        check("t6_restart_addr", req_addr, 32'h0);
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
